// File: rtl/dmem_req_if.sv
// dmem_req_if: one requester's handshake onto the data-memory arbiter.
//   master : requester side (drives req/we/addr/wdata, receives gnt/response)
//   slave  : arbiter side
//   req/we/addr/wdata : access request, held until gnt
//   gnt               : accepted this cycle (combinational)
//   rvalid/rdata/err  : registered response, valid the cycle after gnt
interface dmem_req_if #(
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [31:0]   addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          err;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: two-requester arbiter in front of a single-port data
// memory (DEPTH x DW, combinational read, posedge write).
//   clk, rst_n   : clock, synchronous active-low reset
//   p0           : core load/store port (slave side of dmem_req_if)
//   p1           : test/DMA loader port (slave side of dmem_req_if)
//   mem_address, mem_data_in, mem_write, mem_read : memory drive
//   mem_data_out : memory read data, captured for the winner of a read
// One access is granted per cycle. Out-of-range addresses are still granted
// but the memory access is suppressed and err pulses in the response cycle.
module dmem_port_arbiter #(
  parameter int DW    = 32,
  parameter int DEPTH = 256,
  parameter bit RR_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_req_if.slave     p0,
  dmem_req_if.slave     p1,
  output logic [31:0]   mem_address,
  output logic [DW-1:0] mem_data_in,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [DW-1:0] mem_data_out
);

  logic [1:0]           req, we, gnt;
  logic [1:0][31:0]     addr;
  logic [1:0][DW-1:0]   wdata;

  logic                 win, any_gnt, in_range;
  logic [31:0]          win_addr;

  logic                 last_gnt_q, last_gnt_d;
  logic [1:0]           rvalid_q, rvalid_d;
  logic [1:0]           err_q, err_d;
  logic [1:0][DW-1:0]   rdata_q, rdata_d;

  assign req   = {p1.req, p0.req};
  assign we    = {p1.we, p0.we};
  assign addr  = {p1.addr, p0.addr};
  assign wdata = {p1.wdata, p0.wdata};

  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // Contention: the port that did not win last time goes next.
        2'b11:   gnt = (RR_EN && !last_gnt_q) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end

    win      = gnt[1];
    any_gnt  = |gnt;
    win_addr = addr[win];
    // Full 32-bit compare so wrapped high addresses never alias low words.
    in_range = (win_addr < 32'(DEPTH));

    mem_address = any_gnt ? win_addr   : '0;
    mem_data_in = any_gnt ? wdata[win] : '0;
    mem_write   = any_gnt &  we[win] & in_range;
    mem_read    = any_gnt & ~we[win] & in_range;

    last_gnt_d = any_gnt ? win : last_gnt_q;

    for (int i = 0; i < 2; i++) begin
      rvalid_d[i] = gnt[i] & ~we[i];
      err_d[i]    = gnt[i] & ~in_range;
      // rdata holds between reads; out-of-range reads return zero.
      if (rvalid_d[i]) rdata_d[i] = in_range ? mem_data_out : '0;
      else             rdata_d[i] = rdata_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt_q <= 1'b0;
      rvalid_q   <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign p0.gnt    = gnt[0];
  assign p1.gnt    = gnt[1];
  assign p0.rvalid = rvalid_q[0];
  assign p1.rvalid = rvalid_q[1];
  assign p0.err    = err_q[0];
  assign p1.err    = err_q[1];
  assign p0.rdata  = rdata_q[0];
  assign p1.rdata  = rdata_q[1];

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: round-robin instance checked every cycle
// against a behavioural model, plus a fixed-priority instance for starvation.
module tb_dmem_port_arbiter;
  localparam bit RR = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_req_if #(.DW(32)) p0 ();
  dmem_req_if #(.DW(32)) p1 ();
  dmem_req_if #(.DW(32)) q0 ();
  dmem_req_if #(.DW(32)) q1 ();

  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_write, mem_read;
  logic [31:0] q_address, q_data_in;
  logic        q_write, q_read;
  logic [31:0] q_data_out;
  assign q_data_out = 32'hC0FFEE00;

  // Memory the DUT drives
  logic [31:0] mem [256] = '{default: 32'h0};
  assign mem_data_out = mem[mem_address[7:0]];
  always @(posedge clk) if (mem_write) mem[mem_address[7:0]] <= mem_data_in;

  dmem_port_arbiter #(.DW(32), .DEPTH(256), .RR_EN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .p0(p0.slave), .p1(p1.slave),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write(mem_write), .mem_read(mem_read), .mem_data_out(mem_data_out));

  dmem_port_arbiter #(.DW(32), .DEPTH(256), .RR_EN(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n), .p0(q0.slave), .p1(q1.slave),
    .mem_address(q_address), .mem_data_in(q_data_in),
    .mem_write(q_write), .mem_read(q_read), .mem_data_out(q_data_out));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] ref_mem [256] = '{default: 32'h0};
  int          last = 0;
  logic        armed = 1'b0;
  logic        e_rvalid [2] = '{1'b0, 1'b0};
  logic        e_err    [2] = '{1'b0, 1'b0};
  logic [31:0] e_rdata  [2] = '{32'h0, 32'h0};

  int          win;
  logic [31:0] w_addr, w_data;
  logic        w_we, w_inr;

  always_comb begin
    win = -1;
    if (rst_n) begin
      if (p0.req && p1.req) win = (RR && last == 0) ? 1 : 0;
      else if (p0.req)      win = 0;
      else if (p1.req)      win = 1;
    end
    w_addr = (win == 1) ? p1.addr  : (win == 0) ? p0.addr  : 32'h0;
    w_data = (win == 1) ? p1.wdata : (win == 0) ? p0.wdata : 32'h0;
    w_we   = (win == 1) ? p1.we    : (win == 0) ? p0.we    : 1'b0;
    w_inr  = (w_addr < 32'd256);
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      armed    <= 1'b1;
      last     <= 0;
      e_rvalid <= '{1'b0, 1'b0};
      e_err    <= '{1'b0, 1'b0};
      e_rdata  <= '{32'h0, 32'h0};
    end else begin
      e_rvalid <= '{1'b0, 1'b0};
      e_err    <= '{1'b0, 1'b0};
      if (win >= 0) begin
        last       <= win;
        e_err[win] <= !w_inr;
        if (w_we) begin
          if (w_inr) ref_mem[w_addr[7:0]] <= w_data;
        end else begin
          e_rvalid[win] <= 1'b1;
          e_rdata[win]  <= w_inr ? ref_mem[w_addr[7:0]] : 32'h0;
        end
      end
    end
  end

  // Compare process, away from the active edge
  logic [1:0] pg = 2'b00;
  always @(negedge clk) begin
    pg <= {p1.gnt, p0.gnt};
    if (armed) begin
      chk("p0_gnt", p0.gnt, win == 0);
      chk("p1_gnt", p1.gnt, win == 1);
      chk("mem_write", mem_write, win >= 0 && w_we && w_inr);
      chk("mem_read", mem_read, win >= 0 && !w_we && w_inr);
      chk("mem_address", mem_address, w_addr);
      chk("mem_data_in", mem_data_in, w_data);
      chk("p0_rvalid", p0.rvalid, e_rvalid[0]);
      chk("p1_rvalid", p1.rvalid, e_rvalid[1]);
      chk("p0_err", p0.err, e_err[0]);
      chk("p1_err", p1.err, e_err[1]);
      chk("p0_rdata", p0.rdata, e_rdata[0]);
      chk("p1_rdata", p1.rdata, e_rdata[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0)      return 32'd256 + 32'($urandom_range(0, 255));
    else if (r == 1) return 32'hFFFFFFFF;
    else             return 32'($urandom_range(0, 47));
  endfunction

  initial begin
    int bad;
    p0.req = 0; p0.we = 0; p0.addr = 0; p0.wdata = 0;
    p1.req = 0; p1.we = 0; p1.addr = 0; p1.wdata = 0;
    q0.req = 0; q0.we = 0; q0.addr = 0; q0.wdata = 0;
    q1.req = 0; q1.we = 0; q1.addr = 0; q1.wdata = 0;
    rst_n = 0;
    step();

    // Reset held two cycles with both ports requesting
    p0.req = 1; p0.we = 0; p0.addr = 32'd0;
    p1.req = 1; p1.we = 0; p1.addr = 32'd1;
    repeat (2) begin
      #1;
      chk("rst_gnt", {p1.gnt, p0.gnt}, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_rvalid_err", {p1.rvalid, p0.rvalid, p1.err, p0.err}, 0);
      step();
    end
    rst_n = 1;
    #1 chk("first_gnt_p1", {p1.gnt, p0.gnt}, 2'b10);
    step();
    p1.req = 0;
    #1 chk("then_gnt_p0", {p1.gnt, p0.gnt}, 2'b01);
    step();
    p0.req = 0;

    // Preload memory[5] through port 1, then single read on port 0
    p1.req = 1; p1.we = 1; p1.addr = 32'd5; p1.wdata = 32'hDEADBEEF;
    #1 chk("pre_wr_mem_write", mem_write, 1);
    step();
    p1.req = 0;
    p0.req = 1; p0.we = 0; p0.addr = 32'd5;
    #1 chk("rd_gnt_memread", {p0.gnt, mem_read}, 2'b11);
    step();
    p0.req = 0;
    #1 chk("rd_rvalid", p0.rvalid, 1);
    chk("rd_rdata", p0.rdata, 32'hDEADBEEF);
    step();
    #1 chk("rd_rvalid_drop", p0.rvalid, 0);
    chk("rd_rdata_hold", p0.rdata, 32'hDEADBEEF);

    // Write on p1 then read same address on p0 next cycle
    p1.req = 1; p1.we = 1; p1.addr = 32'd10; p1.wdata = 32'h12345678;
    step();
    p1.req = 0;
    p0.req = 1; p0.we = 0; p0.addr = 32'd10;
    step();
    p0.req = 0;
    #1 chk("wr_rd_rvalid", p0.rvalid, 1);
    chk("wr_rd_rdata", p0.rdata, 32'h12345678);

    // Contention: RR alternates 1,0,1,0; fixed priority starves port 1
    p0.req = 1; p0.we = 0; p0.addr = 32'd5;
    p1.req = 1; p1.we = 0; p1.addr = 32'd10;
    q0.req = 1; q1.req = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_alt", {p1.gnt, p0.gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("fp_p0_wins", {q1.gnt, q0.gnt}, 2'b01);
      step();
    end
    p0.req = 0; p1.req = 0; q0.req = 0; q1.req = 0;

    // Out-of-range write on p0, then out-of-range read on p1
    p0.req = 1; p0.we = 1; p0.addr = 32'd256; p0.wdata = 32'h55;
    #1 chk("oor_wr_gnt_nowrite", {p0.gnt, mem_write}, 2'b10);
    step();
    p0.req = 0;
    #1 chk("oor_wr_err", {p0.err, p0.rvalid}, 2'b10);
    chk("oor_mem0", mem[0], 32'h0);
    p1.req = 1; p1.we = 0; p1.addr = 32'hFFFFFFFF;
    #1 chk("oor_rd_gnt_noread", {p1.gnt, mem_read}, 2'b10);
    step();
    p1.req = 0;
    #1 chk("oor_rd_err_rvalid", {p1.err, p1.rvalid}, 2'b11);
    chk("oor_rd_rdata", p1.rdata, 32'h0);
    step();

    // Reset asserted together with a write: write must not land
    p0.req = 1; p0.we = 1; p0.addr = 32'd3; p0.wdata = 32'hAA;
    rst_n = 0;
    #1 chk("rst_wr_gnt", p0.gnt, 0);
    step();
    rst_n = 1;
    p0.req = 0;
    #1 chk("rst_wr_mem3", mem[3], 32'h0);
    chk("rst_wr_resp", {p0.rvalid, p0.err}, 2'b00);
    step();

    // Randomised traffic; requests held until granted
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if (!(p0.req && !pg[0])) begin
        p0.req = ($urandom_range(0, 3) != 0); p0.we = $urandom_range(0, 1);
        p0.addr = rnd_addr(); p0.wdata = $urandom;
      end
      if (!(p1.req && !pg[1])) begin
        p1.req = ($urandom_range(0, 3) != 0); p1.we = $urandom_range(0, 1);
        p1.addr = rnd_addr(); p1.wdata = $urandom;
      end
      step();
    end
    rst_n = 1; p0.req = 0; p1.req = 0;
    step();
    step();

    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_sweep_mismatches", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
